// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Consumes a byte stream of the form
//     len_lo len_hi | payload[0..N-1] | checksum
// and packs the payload little-endian into 32-bit word writes with byte
// enables.
// The core stays in reset (cpu_hold=1) until an image has been loaded with a
// good length and a matching checksum.
// The checksum is the mod-256 sum of the payload bytes only.

module imem_loader #(
    parameter int DEPTH_BYTES = 128,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic [3:0]    wbe,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        RUN    = 3'd4,
        FAIL   = 3'd5
    } state_t;

    // Capacity widened by one bit so a 16-bit length compares without overflow.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_BYTES);

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] len_r;        // image length N
    logic [15:0] cnt_r;        // index k of the next payload byte
    logic [7:0]  sum_r;        // running mod-256 payload sum
    logic        lenbad_r;     // image too large: consume but never write
    logic [31:0] buf_r;        // partially assembled word
    logic [3:0]  be_r;         // lanes collected in buf_r

    logic        hs_s;
    logic [1:0]  lane_s;
    logic        last_byte_s;
    logic        flush_s;
    logic [15:0] len_full_s;
    logic [31:0] buf_merged_s;
    logic [3:0]  be_merged_s;
    logic        csum_ok_s;

    // Ready whenever a loading state is active; blocked by reset and load_start.
    always_comb begin
        in_ready = 1'b0;
        if (reset || load_start) begin
            in_ready = 1'b0;
        end else begin
            case (state_r)
                LEN_LO, LEN_HI, DATA, CSUM: in_ready = 1'b1;
                default:                    in_ready = 1'b0;
            endcase
        end
    end

    // Per-byte datapath helpers: lane placement, flush decision, checksum test.
    always_comb begin
        hs_s         = in_valid & in_ready;
        lane_s       = cnt_r[1:0];
        last_byte_s  = (cnt_r == (len_r - 16'd1));
        len_full_s   = {in_data, len_r[7:0]};
        buf_merged_s = buf_r | ({24'd0, in_data} << {lane_s, 3'b000});
        be_merged_s  = be_r | (4'b0001 << lane_s);
        csum_ok_s    = (in_data == sum_r) && !lenbad_r;
        if (hs_s && (state_r == DATA) && ((lane_s == 2'd3) || last_byte_s)) begin
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    // Next-state logic: load_start always wins, otherwise advance on a handshake.
    always_comb begin
        state_next_s = state_r;
        if (load_start) begin
            state_next_s = LEN_LO;
        end else if (hs_s) begin
            case (state_r)
                LEN_LO:  state_next_s = LEN_HI;
                LEN_HI:  state_next_s = (len_full_s == 16'd0) ? CSUM : DATA;
                DATA:    state_next_s = last_byte_s ? CSUM : DATA;
                CSUM:    state_next_s = csum_ok_s ? RUN : FAIL;
                default: state_next_s = state_r;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LEN_LO;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: header capture, word packing, registered write port and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r    <= 16'd0;
            cnt_r    <= 16'd0;
            sum_r    <= 8'd0;
            lenbad_r <= 1'b0;
            buf_r    <= 32'd0;
            be_r     <= 4'd0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= 32'd0;
            wbe      <= 4'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            // The write strobe is a one-cycle pulse; any scheduled write
            // has already appeared on the port this cycle.
            we <= 1'b0;
            if (load_start) begin
                len_r    <= 16'd0;
                cnt_r    <= 16'd0;
                sum_r    <= 8'd0;
                lenbad_r <= 1'b0;
                buf_r    <= 32'd0;
                be_r     <= 4'd0;
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (hs_s) begin
                case (state_r)
                    LEN_LO: begin
                        len_r <= {8'd0, in_data};
                    end
                    LEN_HI: begin
                        len_r    <= len_full_s;
                        lenbad_r <= ({1'b0, len_full_s} > DEPTH_L);
                        cnt_r    <= 16'd0;
                        sum_r    <= 8'd0;
                        buf_r    <= 32'd0;
                        be_r     <= 4'd0;
                    end
                    DATA: begin
                        sum_r <= sum_r + in_data;
                        cnt_r <= cnt_r + 16'd1;
                        if (flush_s) begin
                            buf_r <= 32'd0;
                            be_r  <= 4'd0;
                            if (!lenbad_r) begin
                                we    <= 1'b1;
                                waddr <= AW'({cnt_r[15:2], 2'b00});
                                wdata <= buf_merged_s;
                                wbe   <= be_merged_s;
                            end
                        end else begin
                            buf_r <= buf_merged_s;
                            be_r  <= be_merged_s;
                        end
                    end
                    CSUM: begin
                        if (csum_ok_s) begin
                            done     <= 1'b1;
                            err      <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else begin
                            done     <= 1'b0;
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    default: begin
                        sum_r <= sum_r;
                    end
                endcase
            end
        end
    end

endmodule
